// File: rtl/writeback_sequencer.sv
// Feeds write_submodule one element per transaction from a small input FIFO,
// addressing base + i*ADDR_STEP, and reports job completion with the first failing index.
module writeback_sequencer #(
    parameter int unsigned ADDR_WDTH  = 16,
    parameter int unsigned DATA_WDTH  = 32,
    parameter int unsigned RESP_WDTH  = 2,
    parameter int unsigned CNT_WDTH   = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ADDR_STEP  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 job_start,
    input  logic [ADDR_WDTH-1:0] job_base,
    input  logic [CNT_WDTH-1:0]  job_count,
    output logic                 job_busy,
    output logic                 job_done,
    output logic                 job_err,
    output logic [CNT_WDTH-1:0]  err_index,
    output logic [RESP_WDTH-1:0] err_resp,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_WDTH-1:0] in_data,
    output logic                 wr_start,
    output logic [DATA_WDTH-1:0] wr_data,
    output logic [ADDR_WDTH-1:0] wr_addr,
    input  logic                 wr_done,
    input  logic [RESP_WDTH-1:0] wr_resp
);

    localparam int unsigned PTR_WDTH  = $clog2(FIFO_DEPTH);
    localparam int unsigned FCNT_WDTH = PTR_WDTH + 1;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        WAIT,
        FINISH
    } state_e;

    state_e                 state_q, state_d;
    logic [ADDR_WDTH-1:0]   base_q, base_d;
    logic [CNT_WDTH-1:0]    count_q, count_d;
    logic [CNT_WDTH-1:0]    idx_q, idx_d;
    logic [CNT_WDTH-1:0]    acc_q, acc_d;
    logic                   err_q, err_d;
    logic [CNT_WDTH-1:0]    err_index_q, err_index_d;
    logic [RESP_WDTH-1:0]   err_resp_q, err_resp_d;
    logic [DATA_WDTH-1:0]   wr_data_q, wr_data_d;
    logic [ADDR_WDTH-1:0]   wr_addr_q, wr_addr_d;
    logic                   wr_start_q, wr_start_d;
    logic                   job_done_q, job_done_d;
    logic                   job_busy_q, job_busy_d;
    logic                   in_ready_q, in_ready_d;
    logic [PTR_WDTH-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_WDTH-1:0]    wr_ptr_q, wr_ptr_d;
    logic [FCNT_WDTH-1:0]   fcnt_q, fcnt_d;
    logic [DATA_WDTH-1:0]   fifo_mem_q [FIFO_DEPTH];

    logic                   push_c;
    logic                   pop_c;
    logic [ADDR_WDTH-1:0]   addr_off_c;

    assign push_c     = in_valid && in_ready_q;
    assign addr_off_c = ADDR_WDTH'(idx_q) * ADDR_WDTH'(ADDR_STEP);

    // Element storage; occupancy is tracked by the pointers, so no reset is needed here.
    always_ff @(posedge clk) begin
        if (push_c) begin
            fifo_mem_q[wr_ptr_q] <= in_data;
        end
    end

    // Next-state, datapath and registered-output logic.
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        count_d     = count_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        err_d       = err_q;
        err_index_d = err_index_q;
        err_resp_d  = err_resp_q;
        wr_data_d   = wr_data_q;
        wr_addr_d   = wr_addr_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        fcnt_d      = fcnt_q;
        job_done_d  = 1'b0;
        pop_c       = 1'b0;

        case (state_q)
            IDLE: begin
                if (job_start) begin
                    base_d      = job_base;
                    count_d     = job_count;
                    idx_d       = '0;
                    acc_d       = '0;
                    err_d       = 1'b0;
                    err_index_d = '0;
                    err_resp_d  = '0;
                    state_d     = (job_count == '0) ? FINISH : FETCH;
                end
            end
            FETCH: begin
                if (fcnt_q != '0) begin
                    pop_c     = 1'b1;
                    wr_data_d = fifo_mem_q[rd_ptr_q];
                    wr_addr_d = base_q + addr_off_c;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (wr_done) begin
                    if ((wr_resp != '0) && !err_q) begin
                        err_d       = 1'b1;
                        err_index_d = idx_q;
                        err_resp_d  = wr_resp;
                    end
                    idx_d   = idx_q + CNT_WDTH'(1);
                    state_d = (err_d || (idx_d == count_q)) ? FINISH : FETCH;
                end
            end
            FINISH: begin
                job_done_d = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (push_c) begin
            wr_ptr_d = wr_ptr_q + PTR_WDTH'(1);
            acc_d    = acc_q + CNT_WDTH'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_WDTH'(1);
        end
        fcnt_d = fcnt_q + FCNT_WDTH'(push_c) - FCNT_WDTH'(pop_c);

        // Leftover elements of an aborted job are discarded.
        if (state_q == FINISH) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            fcnt_d   = '0;
        end

        wr_start_d = (state_d == ISSUE);
        job_busy_d = (state_d != IDLE);
        in_ready_d = (state_d != IDLE) && (state_d != FINISH)
                     && (fcnt_d != FCNT_WDTH'(FIFO_DEPTH))
                     && (acc_d < count_d) && !err_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            base_q      <= '0;
            count_q     <= '0;
            idx_q       <= '0;
            acc_q       <= '0;
            err_q       <= 1'b0;
            err_index_q <= '0;
            err_resp_q  <= '0;
            wr_data_q   <= '0;
            wr_addr_q   <= '0;
            wr_start_q  <= 1'b0;
            job_done_q  <= 1'b0;
            job_busy_q  <= 1'b0;
            in_ready_q  <= 1'b0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            fcnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            count_q     <= count_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            err_q       <= err_d;
            err_index_q <= err_index_d;
            err_resp_q  <= err_resp_d;
            wr_data_q   <= wr_data_d;
            wr_addr_q   <= wr_addr_d;
            wr_start_q  <= wr_start_d;
            job_done_q  <= job_done_d;
            job_busy_q  <= job_busy_d;
            in_ready_q  <= in_ready_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            fcnt_q      <= fcnt_d;
        end
    end

    assign job_busy  = job_busy_q;
    assign job_done  = job_done_q;
    assign job_err   = err_q;
    assign err_index = err_index_q;
    assign err_resp  = err_resp_q;
    assign in_ready  = in_ready_q;
    assign wr_start  = wr_start_q;
    assign wr_data   = wr_data_q;
    assign wr_addr   = wr_addr_q;

endmodule

// File: tb/tb_writeback_sequencer.sv
// Directed bench for writeback_sequencer with a simple write_submodule responder.
module tb_writeback_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        job_start;
    logic [15:0] job_base;
    logic [7:0]  job_count;
    logic        job_busy, job_done, job_err;
    logic [7:0]  err_index;
    logic [1:0]  err_resp;
    logic        in_valid, in_ready;
    logic [31:0] in_data;
    logic        wr_start;
    logic [31:0] wr_data;
    logic [15:0] wr_addr;
    logic        wr_done;
    logic [1:0]  wr_resp;

    int tests = 0;
    int fails = 0;

    // Results collected by run_job
    int          n_starts, sent, done_cyc, first_drop_sent;
    bit          ready_seen, r_done, busy_at_done;
    logic        r_err;
    logic [7:0]  r_idx;
    logic [1:0]  r_resp;
    int          start_cyc [16];
    logic [15:0] r_addr [16];
    logic [31:0] r_data [16];
    logic [31:0] src_data [16];
    logic [62:0] obs;

    always #5 clk = ~clk;

    writeback_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .job_start(job_start), .job_base(job_base), .job_count(job_count),
        .job_busy(job_busy), .job_done(job_done), .job_err(job_err),
        .err_index(err_index), .err_resp(err_resp),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .wr_start(wr_start), .wr_data(wr_data), .wr_addr(wr_addr),
        .wr_done(wr_done), .wr_resp(wr_resp)
    );

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Runs one job: streams src_data, answers each wr_start after `delay` cycles.
    task automatic run_job(input logic [15:0] base, input logic [7:0] cnt, input int delay,
                           input int err_at, input logic [1:0] err_val, input bit lazy,
                           input int spur_cyc);
        int tmr, k, resp_n, post;
        bit fire, done_prev;
        n_starts = 0; sent = 0; done_cyc = -1; first_drop_sent = -1;
        ready_seen = 0; r_done = 0; busy_at_done = 1; r_err = 0; r_idx = 0; r_resp = 0;
        tmr = 0; k = 0; resp_n = 0; post = 0; fire = 0; done_prev = 0;
        @(negedge clk);
        job_base = base; job_count = cnt; job_start = 1'b1;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(negedge clk);
            job_start = (cyc == spur_cyc);
            if (job_start) begin
                job_base = 16'hDEAD; job_count = 8'd9;
            end
            if (fire) sent++;
            if (done_prev) k++;
            if (in_ready) ready_seen = 1;
            wr_done = 1'b0;
            if (tmr > 0) begin
                tmr--;
                if (tmr == 0) begin
                    wr_done = 1'b1;
                    wr_resp = (resp_n == err_at) ? err_val : 2'd0;
                    resp_n++;
                end
            end
            if (wr_start) begin
                if (n_starts < 16) begin
                    r_addr[n_starts] = wr_addr;
                    r_data[n_starts] = wr_data;
                    start_cyc[n_starts] = cyc;
                end
                n_starts++;
                tmr = delay;
            end
            if (job_done && !r_done) begin
                r_done = 1; done_cyc = cyc; r_err = job_err;
                r_idx = err_index; r_resp = err_resp; busy_at_done = job_busy;
            end
            done_prev = wr_done;
            in_valid = (sent < int'(cnt)) && (sent < 16) && (!lazy || sent <= k);
            in_data = src_data[(sent < 16) ? sent : 0];
            if (in_valid && !in_ready && job_busy && first_drop_sent < 0) first_drop_sent = sent;
            fire = in_valid && in_ready;
            if (r_done) post++;
            if (post > 4) break;
        end
        in_valid = 1'b0; wr_done = 1'b0; job_start = 1'b0;
        tests++;
        if (!r_done) begin
            fails++;
            $display("FAIL run_timeout job_done got 0 exp 1 (base %h count %0d)", base, cnt);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; job_start = 0; job_base = 0; job_count = 0;
        in_valid = 0; in_data = 0; wr_done = 0; wr_resp = 0;
        repeat (2) @(negedge clk);
        obs = {job_busy, job_done, job_err, err_index, err_resp, in_ready, wr_start, wr_data, wr_addr};
        tests++;
        if (obs !== '0) begin
            fails++; $display("FAIL reset_outputs got %h exp 0", obs);
        end
        rst_n = 1'b1;
        @(negedge clk); wr_done = 1'b1; wr_resp = 2'd3;
        @(negedge clk); wr_done = 1'b0; wr_resp = 2'd0;
        @(negedge clk);
        tests++;
        if ({job_busy, wr_start, job_done, job_err} !== 4'b0) begin
            fails++;
            $display("FAIL spurious_done got %b exp 0000", {job_busy, wr_start, job_done, job_err});
        end
    endtask

    task automatic test_basic();
        logic [15:0] ea [3];
        int          ec [3];
        ea[0] = 16'h0100; ea[1] = 16'h0104; ea[2] = 16'h0108;
        ec[0] = 3; ec[1] = 6; ec[2] = 9;
        src_data[0] = 32'hAAAA_0001; src_data[1] = 32'hBBBB_0002; src_data[2] = 32'hCCCC_0003;
        run_job(16'h0100, 8'd3, 1, -1, 2'd0, 1'b0, -1);
        tests++;
        if (n_starts !== 3) begin fails++; $display("FAIL basic_starts got %0d exp 3", n_starts); end
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (r_addr[i] !== ea[i] || r_data[i] !== src_data[i]) begin
                fails++;
                $display("FAIL basic_elem%0d got %h/%h exp %h/%h", i, r_addr[i], r_data[i], ea[i], src_data[i]);
            end
            tests++;
            if (start_cyc[i] !== ec[i]) begin
                fails++; $display("FAIL basic_start_cyc%0d got %0d exp %0d", i, start_cyc[i], ec[i]);
            end
        end
        tests++;
        if (done_cyc !== 12 || r_err !== 1'b0 || busy_at_done !== 1'b0) begin
            fails++;
            $display("FAIL basic_done got cyc %0d err %b busy %b exp 12 0 0", done_cyc, r_err, busy_at_done);
        end
    endtask

    task automatic test_zero_count();
        run_job(16'h0400, 8'd0, 1, -1, 2'd0, 1'b0, -1);
        tests++;
        if (done_cyc !== 2 || n_starts !== 0 || ready_seen !== 1'b0 || r_err !== 1'b0) begin
            fails++;
            $display("FAIL zero_count got cyc %0d starts %0d ready %b err %b exp 2 0 0 0",
                     done_cyc, n_starts, ready_seen, r_err);
        end
    endtask

    task automatic test_error_abort();
        for (int i = 0; i < 5; i++) src_data[i] = 32'h5000_0000 + i;
        run_job(16'h0200, 8'd5, 1, 1, 2'd2, 1'b1, -1);
        tests++;
        if (n_starts !== 2 || sent !== 2) begin
            fails++; $display("FAIL err_starts got starts %0d accepted %0d exp 2 2", n_starts, sent);
        end
        tests++;
        if (r_err !== 1'b1 || r_idx !== 8'd1 || r_resp !== 2'd2) begin
            fails++;
            $display("FAIL err_report got err %b idx %0d resp %0d exp 1 1 2", r_err, r_idx, r_resp);
        end
        tests++;
        if (r_addr[1] !== 16'h0204 || r_data[1] !== 32'h5000_0001) begin
            fails++; $display("FAIL err_elem1 got %h/%h exp 0204/50000001", r_addr[1], r_data[1]);
        end
        tests++;
        if (job_err !== 1'b1 || err_index !== 8'd1 || err_resp !== 2'd2) begin
            fails++;
            $display("FAIL err_hold got %b %0d %0d exp 1 1 2", job_err, err_index, err_resp);
        end
    endtask

    task automatic test_fifo_full();
        int bad;
        for (int i = 0; i < 8; i++) src_data[i] = 32'hF00D_0000 + (i * 17);
        run_job(16'h1000, 8'd8, 10, -1, 2'd0, 1'b0, -1);
        tests++;
        if (first_drop_sent !== 5) begin
            fails++; $display("FAIL full_drop accepted-at-drop got %0d exp 5", first_drop_sent);
        end
        tests++;
        if (n_starts !== 8 || sent !== 8 || r_err !== 1'b0) begin
            fails++;
            $display("FAIL full_counts got starts %0d accepted %0d err %b exp 8 8 0", n_starts, sent, r_err);
        end
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            if (r_addr[i] !== 16'h1000 + 16'(i * 4) || r_data[i] !== src_data[i]) bad++;
        end
        tests++;
        if (bad !== 0) begin fails++; $display("FAIL full_order got %0d bad elements exp 0", bad); end
    endtask

    task automatic test_wrap();
        src_data[0] = 32'h1234_5678; src_data[1] = 32'h9ABC_DEF0;
        run_job(16'hFFFC, 8'd2, 1, -1, 2'd0, 1'b0, -1);
        tests++;
        if (n_starts !== 2 || r_addr[0] !== 16'hFFFC || r_addr[1] !== 16'h0000) begin
            fails++;
            $display("FAIL wrap_addr got %0d starts %h %h exp 2 FFFC 0000", n_starts, r_addr[0], r_addr[1]);
        end
    endtask

    task automatic test_reset_mid_job();
        bit seen;
        @(negedge clk);
        job_base = 16'h0200; job_count = 8'd3; job_start = 1'b1;
        in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
        @(negedge clk);
        job_start = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (wr_start) begin seen = 1; break; end
            @(negedge clk);
        end
        tests++;
        if (!seen) begin fails++; $display("FAIL rst_mid_start got no wr_start exp one"); end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        obs = {job_busy, job_done, job_err, err_index, err_resp, in_ready, wr_start, wr_data, wr_addr};
        tests++;
        if (obs !== '0) begin fails++; $display("FAIL rst_mid_outputs got %h exp 0", obs); end
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        src_data[0] = 32'h0000_0A0A; src_data[1] = 32'h0000_0B0B;
        run_job(16'h0300, 8'd2, 2, -1, 2'd0, 1'b0, 4);
        tests++;
        if (n_starts !== 2 || r_addr[0] !== 16'h0300 || r_addr[1] !== 16'h0304
            || r_data[0] !== 32'h0000_0A0A || r_data[1] !== 32'h0000_0B0B) begin
            fails++;
            $display("FAIL rst_rerun got %0d starts %h/%h %h/%h exp 2 0300/a0a 0304/b0b",
                     n_starts, r_addr[0], r_data[0], r_addr[1], r_data[1]);
        end
        tests++;
        if (r_err !== 1'b0 || job_busy !== 1'b0) begin
            fails++; $display("FAIL rst_rerun_idle got err %b busy %b exp 0 0", r_err, job_busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_count();
        test_error_abort();
        test_fifo_full();
        test_wrap();
        test_reset_mid_job();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
